// File: rtl/dispatch_sink.sv
`timescale 1ns/1ps
// dispatch_sink: serializes network timesteps and SNC/CLR commands into RUN/SPK/SNC/CLR packets.
// Define DISPATCH_SINK_RUN_COALESCE_EN to merge zero-vector timesteps into one RUN count.
module dispatch_sink #(
    parameter int NUM_OUT   = 8,
    parameter int RUN_WIDTH = 8,
    parameter int IDX_WIDTH = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
    parameter int PKT_WIDTH = 2 + ((IDX_WIDTH > RUN_WIDTH) ? IDX_WIDTH : RUN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 net_valid,
    output logic                 net_ready,
    input  logic [NUM_OUT-1:0]   net_out,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic [PKT_WIDTH-1:0] pkt_data
);
    localparam int PL_WIDTH = PKT_WIDTH - 2;
    localparam logic [1:0] OP_RUN = 2'd0;
    localparam logic [1:0] OP_SPK = 2'd1;
    localparam logic [1:0] OP_SNC = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    typedef enum logic [2:0] {IDLE, RUNF, SCAN, SYNC, CLEAR} state_t;

    state_t               state_reg, state_next;
    logic [NUM_OUT-1:0]   mask_reg, mask_next, mask_rest;
    logic                 snc_pend_reg, snc_pend_next;
    logic [IDX_WIDTH-1:0] low_idx;
    logic                 net_fire, cmd_fire;
`ifdef DISPATCH_SINK_RUN_COALESCE_EN
    logic [RUN_WIDTH-1:0] run_cnt_reg, run_cnt_next, run_inc;
    assign run_inc = run_cnt_reg + RUN_WIDTH'(1);
`endif

    // Commands take priority: a pending command masks timestep readiness.
    assign cmd_ready = (state_reg == IDLE) && !rst;
    assign net_ready = (state_reg == IDLE) && !rst && !cmd_valid;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign net_fire  = net_valid && net_ready;

    // Mask with its lowest set bit removed; zero means the current SPK is the last.
    assign mask_rest = mask_reg & (mask_reg - NUM_OUT'(1));

    always_comb begin
        low_idx = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (mask_reg[i]) low_idx = IDX_WIDTH'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            mask_reg     <= '0;
            snc_pend_reg <= 1'b0;
`ifdef DISPATCH_SINK_RUN_COALESCE_EN
            run_cnt_reg  <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            mask_reg     <= mask_next;
            snc_pend_reg <= snc_pend_next;
`ifdef DISPATCH_SINK_RUN_COALESCE_EN
            run_cnt_reg  <= run_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        mask_next     = mask_reg;
        snc_pend_next = snc_pend_reg;
`ifdef DISPATCH_SINK_RUN_COALESCE_EN
        run_cnt_next  = run_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_SNC: begin
`ifdef DISPATCH_SINK_RUN_COALESCE_EN
                            // Flush the pending count first so the host sees it before the sync.
                            if (run_cnt_reg != '0) begin
                                snc_pend_next = 1'b1;
                                state_next    = RUNF;
                            end else begin
                                state_next    = SYNC;
                            end
`else
                            state_next = SYNC;
`endif
                        end
                        OP_CLR: begin
`ifdef DISPATCH_SINK_RUN_COALESCE_EN
                            run_cnt_next = '0;
`endif
                            state_next = CLEAR;
                        end
                        default: ;
                    endcase
                end else if (net_fire) begin
`ifdef DISPATCH_SINK_RUN_COALESCE_EN
                    // run_cnt holds the RUN payload while in RUNF; it never exceeds the all-ones flush value.
                    run_cnt_next = run_inc;
                    if (net_out != '0) begin
                        mask_next  = net_out;
                        state_next = RUNF;
                    end else if (run_inc == '1) begin
                        state_next = RUNF;
                    end
`else
                    mask_next  = net_out;
                    state_next = RUNF;
`endif
                end
            end
            RUNF: begin
                if (pkt_ready) begin
`ifdef DISPATCH_SINK_RUN_COALESCE_EN
                    run_cnt_next = '0;
`endif
                    if (mask_reg != '0)   state_next = SCAN;
                    else if (snc_pend_reg) state_next = SYNC;
                    else                   state_next = IDLE;
                end
            end
            SCAN: begin
                if (pkt_ready) begin
                    mask_next = mask_rest;
                    if (mask_rest == '0) state_next = IDLE;
                end
            end
            SYNC: begin
                if (pkt_ready) begin
                    snc_pend_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            CLEAR: begin
                if (pkt_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pkt_valid = 1'b0;
        pkt_data  = '0;
        case (state_reg)
            RUNF: begin
                pkt_valid = 1'b1;
`ifdef DISPATCH_SINK_RUN_COALESCE_EN
                pkt_data  = {OP_RUN, PL_WIDTH'(run_cnt_reg)};
`else
                pkt_data  = {OP_RUN, PL_WIDTH'(1)};
`endif
            end
            SCAN: begin
                pkt_valid = 1'b1;
                pkt_data  = {OP_SPK, PL_WIDTH'(low_idx)};
            end
            SYNC: begin
                pkt_valid = 1'b1;
                pkt_data  = {OP_SNC, PL_WIDTH'(0)};
            end
            CLEAR: begin
                pkt_valid = 1'b1;
                pkt_data  = {OP_CLR, PL_WIDTH'(0)};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dispatch_sink.sv
`timescale 1ns/1ps
// tb_dispatch_sink: scoreboard bench; expected packets are queued as timesteps/commands are accepted.
module tb_dispatch_sink;
    logic       clk = 1'b0;
    logic       rst;
    logic       net_valid;
    logic       net_ready;
    logic [7:0] net_out;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [9:0] pkt_data;

    logic [9:0] sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         model_cnt = 0;
    logic       stall_prev = 1'b0;
    logic [9:0] stall_data = '0;

    dispatch_sink dut (
        .clk(clk), .rst(rst),
        .net_valid(net_valid), .net_ready(net_ready), .net_out(net_out),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] mk(input logic [1:0] op, input int pl);
        return {op, 8'(pl)};
    endfunction

    task automatic model_step(input logic [7:0] v);
`ifdef DISPATCH_SINK_RUN_COALESCE_EN
        if (v != 8'h00) begin
            sb.push_back(mk(2'd0, model_cnt + 1));
            model_cnt = 0;
            for (int i = 0; i < 8; i++) if (v[i]) sb.push_back(mk(2'd1, i));
        end else begin
            model_cnt++;
            if (model_cnt == 255) begin
                sb.push_back(mk(2'd0, 255));
                model_cnt = 0;
            end
        end
`else
        sb.push_back(mk(2'd0, 1));
        for (int i = 0; i < 8; i++) if (v[i]) sb.push_back(mk(2'd1, i));
`endif
    endtask

    task automatic model_cmd(input logic [1:0] op);
        if (op == 2'd2) begin
`ifdef DISPATCH_SINK_RUN_COALESCE_EN
            if (model_cnt > 0) sb.push_back(mk(2'd0, model_cnt));
`endif
            model_cnt = 0;
            sb.push_back(mk(2'd2, 0));
        end else if (op == 2'd3) begin
            model_cnt = 0;
            sb.push_back(mk(2'd3, 0));
        end
    endtask

    // Output monitor: hold check on stalls, scoreboard compare on handshakes.
    initial begin
        logic [9:0] exp_pkt;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                n_vec++;
                if (pkt_valid !== 1'b1 || pkt_data !== stall_data) begin
                    n_err++;
                    $display("FAIL stall_hold: got valid=%b data=%h, need valid=1 data=%h",
                             pkt_valid, pkt_data, stall_data);
                end
            end
            if (rst !== 1'b1 && pkt_valid === 1'b1 && pkt_ready === 1'b1) begin
                n_vec++;
                $display("pkt op=%0d payload=%0d", pkt_data[9:8], pkt_data[7:0]);
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pkt: got %h, need no packet", pkt_data);
                end else begin
                    exp_pkt = sb.pop_front();
                    if (pkt_data !== exp_pkt) begin
                        n_err++;
                        $display("FAIL pkt_data: got %h, need %h", pkt_data, exp_pkt);
                    end
                end
            end
            stall_prev = (rst !== 1'b1) && (pkt_valid === 1'b1) && (pkt_ready === 1'b0);
            stall_data = pkt_data;
        end
    end

    task automatic send_step(input logic [7:0] v);
        bit ok = 0;
        net_out   = v;
        net_valid = 1'b1;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            if (net_ready === 1'b1) ok = 1;
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL step_accept: got net_ready=%b, need 1 within 1000 cycles", net_ready);
        end else begin
            model_step(v);
            $display("step accepted vec=%h", v);
        end
        @(posedge clk); #1;
        net_valid = 1'b0;
        net_out   = '0;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        bit ok = 0;
        cmd_op    = op;
        cmd_valid = 1'b1;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) ok = 1;
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL cmd_accept: got cmd_ready=%b, need 1 within 1000 cycles", cmd_ready);
        end else begin
            model_cmd(op);
            $display("cmd accepted op=%0d", op);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 2000 && sb.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_%s: got %0d packets outstanding, need 0", name, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; net_valid = 1'b0; net_out = '0; cmd_valid = 1'b0; cmd_op = '0; pkt_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (net_ready !== 1'b0) begin n_err++; $display("FAIL rst_net_ready: got %b, need 0", net_ready); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %b, need 0", cmd_ready); end
        n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL rst_pkt_valid: got %b, need 0", pkt_valid); end
        n_vec++; if (pkt_data !== 10'h000) begin n_err++; $display("FAIL rst_pkt_data: got %h, need 000", pkt_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (net_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_net_ready: got %b, need 1", net_ready); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_cmd_ready: got %b, need 1", cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int  low = 0;
        bit  done = 0;
        pkt_ready = 1'b1;
        repeat (3) send_step(8'h00);
        send_step(8'b1000_0101);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (net_ready === 1'b1) done = 1;
            else begin
                low++;
                n_vec++;
                if (pkt_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL basic_back_to_back: got pkt_valid=%b in busy cycle %0d, need 1", pkt_valid, low);
                end
            end
        end
        n_vec++;
        if (low != 4) begin
            n_err++;
            $display("FAIL basic_busy_cycles: got %0d, need 4", low);
        end
        wait_drain("basic");
    endtask

    task automatic test_saturation();
        pkt_ready = 1'b1;
        for (int i = 0; i < 255; i++) send_step(8'h00);
        send_step(8'h00);
        send_cmd(2'd2);
        wait_drain("saturation");
    endtask

    task automatic test_snc_priority();
        bit ok = 0;
        pkt_ready = 1'b1;
        repeat (2) send_step(8'h00);
        net_out = 8'h10; net_valid = 1'b1;
        cmd_op = 2'd2;   cmd_valid = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) ok = 1;
        end
        n_vec++;
        if (!ok || net_ready !== 1'b0) begin
            n_err++;
            $display("FAIL snc_priority: got cmd_ready=%b net_ready=%b, need 1 and 0", cmd_ready, net_ready);
        end
        if (ok) model_cmd(2'd2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (net_ready === 1'b1) ok = 1;
        end
        n_vec++;
        if (!ok || pkt_valid !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL snc_step_order: got accept=%0d pkt_valid=%b pending=%0d, need 1 0 0",
                     ok, pkt_valid, sb.size());
        end
        if (ok) model_step(8'h10);
        @(posedge clk); #1;
        net_valid = 1'b0; net_out = '0;
        wait_drain("snc");
    endtask

    task automatic test_clr_illegal();
        pkt_ready = 1'b1;
        repeat (5) send_step(8'h00);
        send_cmd(2'd3);
        wait_drain("clr");
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_op = (i < 3) ? 2'd0 : 2'd1;
            @(negedge clk);
            n_vec++;
            if (cmd_ready !== 1'b1 || pkt_valid !== 1'b0) begin
                n_err++;
                $display("FAIL illegal_cmd: got cmd_ready=%b pkt_valid=%b, need 1 0", cmd_ready, pkt_valid);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        send_cmd(2'd2);
        wait_drain("after_clr");
    endtask

    task automatic test_backpressure();
        pkt_ready = 1'b0;
        send_step(8'h03);
        for (int c = 0; c < 100 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
            pkt_ready = ~pkt_ready;
        end
        pkt_ready = 1'b1;
        wait_drain("backpressure");
    endtask

    task automatic test_reset_mid_packet();
        pkt_ready = 1'b0;
        send_step(8'h03);
        pkt_ready = 1'b1;
        @(posedge clk); #1;
        pkt_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (pkt_valid !== 1'b1 || pkt_data !== mk(2'd1, 0)) begin
            n_err++;
            $display("FAIL stall_spk0: got valid=%b data=%h, need 1 %h", pkt_valid, pkt_data, mk(2'd1, 0));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (pkt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_abandon: got pkt_valid=%b, need 0", pkt_valid);
        end
        rst = 1'b0;
        sb.delete();
        model_cnt = 0;
        @(negedge clk);
        n_vec++;
        if (net_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_recover: got net_ready=%b, need 1", net_ready);
        end
        @(posedge clk); #1;
        pkt_ready = 1'b1;
        send_step(8'h80);
        wait_drain("after_rst");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_snc_priority();
        test_clr_illegal();
        test_backpressure();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
